// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM that steps the register-file/ALU datapath through one
// 16-bit instruction per start strobe, then pulses done (with err for bad encodings).
module datapath_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s,
  input  logic [15:0]      instr,
  output logic             w,
  output logic [2:0]       readnum,
  output logic [2:0]       writenum,
  output logic             write,
  output logic             loada,
  output logic             loadb,
  output logic             loadc,
  output logic             loads,
  output logic             asel,
  output logic             bsel,
  output logic [1:0]       vsel,
  output logic [1:0]       shift,
  output logic [1:0]       aluop,
  output logic [WIDTH-1:0] sximm8,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    StIdle, StDecode, StWrImm, StLdA, StLdB, StExec, StWrReg, StDone
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] ir_q;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_movi, is_movr, is_alu, is_cmp, is_mvn, illegal;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu  = (opcode == 3'b101);
  assign is_cmp  = is_alu && (op == 2'b01);
  assign is_mvn  = is_alu && (op == 2'b11);
  assign illegal = !(is_movi || is_movr || is_alu);

  assign sximm8 = {{(WIDTH-8){ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      // IR is only written on acceptance, so it holds steady while busy.
      if (state_q == StIdle && s) ir_q <= instr;
    end
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    vsel     = 2'b00;
    shift    = 2'b00;
    aluop    = 2'b00;
    done     = 1'b0;
    err      = 1'b0;

    unique case (state_q)
      StIdle: begin
        w = 1'b1;
        if (s) state_d = StDecode;
      end
      StDecode: begin
        if (illegal)                 state_d = StDone;
        else if (is_movi)            state_d = StWrImm;
        else if (is_movr || is_mvn)  state_d = StLdB;
        else                         state_d = StLdA;
      end
      StWrImm: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
        state_d  = StDone;
      end
      StLdA: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = StLdB;
      end
      StLdB: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = StExec;
      end
      StExec: begin
        shift = sh;
        if (is_movr) begin
          asel  = 1'b1;
          aluop = 2'b00;
        end else if (is_mvn) begin
          asel  = 1'b1;
          aluop = 2'b11;
        end else begin
          aluop = op;
        end
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = StDone;
        end else begin
          loadc   = 1'b1;
          state_d = StWrReg;
        end
      end
      StWrReg: begin
        writenum = rd;
        write    = 1'b1;
        state_d  = StDone;
      end
      StDone: begin
        done    = 1'b1;
        err     = illegal;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: inputs driven and outputs sampled on the
// falling edge; cycle k is the k-th falling edge after the accepting rising edge.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        reset, s;
  logic [15:0] instr;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, done, err;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, shift, aluop;
  logic [15:0] sximm8;

  int checks = 0;
  int errors = 0;
  int done_cnt;
  int first_done, second_done;

  datapath_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .aluop(aluop),
    .sximm8(sximm8), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Call right after a falling edge; returns at cycle 1 with s dropped.
  task automatic go(input logic [15:0] ins);
    s = 1'b1;
    instr = ins;
    @(negedge clk);
    s = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s = 1'b0;
    instr = 16'h0000;
    @(negedge clk);
    @(negedge clk);
    chk("rst_w", w, 1);
    chk("rst_write", write, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sximm8", sximm8, 0);
    chk("rst_readnum", readnum, 0);
    chk("rst_aluop", aluop, 0);
    reset = 1'b0;
    @(negedge clk);

    // MOV R3,#-5
    go(16'hD3FB);
    chk("movi_c1_w", w, 0);
    chk("movi_c1_write", write, 0);
    @(negedge clk);
    chk("movi_c2_write", write, 1);
    chk("movi_c2_writenum", writenum, 3);
    chk("movi_c2_vsel", vsel, 2'b10);
    chk("movi_c2_sximm8", sximm8, 16'hFFFB);
    chk("movi_c2_done", done, 0);
    @(negedge clk);
    chk("movi_c3_done", done, 1);
    chk("movi_c3_err", err, 0);
    chk("movi_c3_write", write, 0);
    @(negedge clk);
    chk("movi_c4_w", w, 1);

    // ADD R2,R1,R0 LSL
    go(16'hA148);
    chk("add_c1_loada", loada, 0);
    @(negedge clk);
    chk("add_c2_loada", loada, 1);
    chk("add_c2_readnum", readnum, 1);
    @(negedge clk);
    chk("add_c3_loadb", loadb, 1);
    chk("add_c3_readnum", readnum, 0);
    @(negedge clk);
    chk("add_c4_loadc", loadc, 1);
    chk("add_c4_aluop", aluop, 2'b00);
    chk("add_c4_shift", shift, 2'b01);
    chk("add_c4_asel", asel, 0);
    chk("add_c4_write", write, 0);
    @(negedge clk);
    chk("add_c5_write", write, 1);
    chk("add_c5_writenum", writenum, 2);
    chk("add_c5_vsel", vsel, 0);
    chk("add_c5_done", done, 0);
    @(negedge clk);
    chk("add_c6_done", done, 1);
    chk("add_c6_err", err, 0);
    @(negedge clk);

    // CMP R5,R6
    go(16'hAD06);
    for (int c = 1; c <= 5; c++) begin
      chk("cmp_nowrite", write, 0);
      if (c == 2) chk("cmp_c2_readnum", readnum, 5);
      if (c == 3) chk("cmp_c3_readnum", readnum, 6);
      if (c == 4) begin
        chk("cmp_c4_loads", loads, 1);
        chk("cmp_c4_loadc", loadc, 0);
        chk("cmp_c4_aluop", aluop, 2'b01);
      end
      chk("cmp_done", done, (c == 5) ? 1 : 0);
      if (c < 5) @(negedge clk);
    end
    chk("cmp_c5_err", err, 0);
    @(negedge clk);

    // Illegal encoding
    go(16'hE000);
    chk("ill_c1_strobes", {write, loada, loadb, loadc, loads}, 0);
    chk("ill_c1_done", done, 0);
    @(negedge clk);
    chk("ill_c2_done", done, 1);
    chk("ill_c2_err", err, 1);
    chk("ill_c2_strobes", {write, loada, loadb, loadc, loads}, 0);
    @(negedge clk);
    chk("ill_c3_w", w, 1);

    // MVN R4,R7 ASR-ish shift, with s toggling while busy
    go(16'hB897);
    done_cnt = 0;
    for (int c = 1; c <= 6; c++) begin
      s = (c <= 4) ? c[0] : 1'b0;
      instr = 16'hD3FB;
      if (done) done_cnt++;
      if (c == 2) begin
        chk("mvn_c2_loadb", loadb, 1);
        chk("mvn_c2_readnum", readnum, 7);
        chk("mvn_c2_loada", loada, 0);
      end
      if (c == 3) begin
        chk("mvn_c3_asel", asel, 1);
        chk("mvn_c3_aluop", aluop, 2'b11);
        chk("mvn_c3_shift", shift, 2'b10);
        chk("mvn_c3_loadc", loadc, 1);
      end
      if (c == 4) begin
        chk("mvn_c4_write", write, 1);
        chk("mvn_c4_writenum", writenum, 4);
        chk("mvn_c4_ir_kept", sximm8, 16'hFF97);
      end
      if (c == 5) chk("mvn_c5_done", done, 1);
      @(negedge clk);
    end
    chk("mvn_done_count", done_cnt, 1);
    chk("mvn_idle_after", w, 1);

    // Back-to-back MOV R1,#5 with s held high
    s = 1'b1;
    instr = 16'hD105;
    first_done = 0;
    second_done = 0;
    done_cnt = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 5) s = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        if (done_cnt == 2) second_done = c;
      end
      if (c == 4) chk("b2b_c4_idle", w, 1);
    end
    chk("b2b_done_count", done_cnt, 2);
    chk("b2b_first_done", first_done, 3);
    chk("b2b_spacing", second_done - first_done, 4);

    // Reset during EXEC of ADD
    @(negedge clk);
    go(16'hA148);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rsx_c4_loadc", loadc, 1);
    reset = 1'b1;
    #1;
    chk("rsx_w", w, 1);
    chk("rsx_write", write, 0);
    chk("rsx_loadc", loadc, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rsx_no_write", {write, loadc}, 0);
      @(negedge clk);
    end
    go(16'hD3FB);
    @(negedge clk);
    chk("rsx_movi_write", write, 1);
    chk("rsx_movi_writenum", writenum, 3);
    @(negedge clk);
    chk("rsx_movi_done", done, 1);
    chk("rsx_movi_err", err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
Name: datapath_sequencer

Overview:
Multi-cycle FSM that sequences the register-file/ALU datapath for one 16-bit instruction at a time. It latches an instruction on a start strobe, decodes it, and drives readnum, writenum, write, loada, loadb, loadc, loads, asel, bsel, vsel, shift and aluop in order. It then pulses done and returns to idle. It sits between instruction fetch and the register file plus its A/B/C pipeline registers.

Parameters:
WIDTH, 16, datapath width; sximm8 is sign-extended to WIDTH bits.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; forces IDLE
s  input  1  start; sampled only in IDLE
instr  input  16  instruction; captured into IR when s is accepted
w  output  1  ready; 1 only in IDLE
readnum  output  3  register-file read index
writenum  output  3  register-file write index
write  output  1  register-file write enable
loada  output  1  load A register
loadb  output  1  load B register
loadc  output  1  load C (ALU result) register
loads  output  1  load status flags
asel  output  1  1 = ALU A operand forced to 0
bsel  output  1  1 = ALU B operand is sximm8
vsel  output  2  write-back source: 00 = C, 10 = sximm8
shift  output  2  B-path shift control
aluop  output  2  00 add, 01 sub, 10 and, 11 not-B
sximm8  output  WIDTH  sign-extended IR[7:0]
done  output  1  one-cycle pulse on completion
err  output  1  one-cycle pulse with done for an illegal encoding

Behaviour:
- Instruction fields: opcode=IR[15:13], op=IR[12:11], Rn=IR[10:8], Rd=IR[7:5], sh=IR[4:3], Rm=IR[2:0].
- Legal encodings:
  - 110/10: MOV Rn,#imm
  - 110/00: MOV Rd,Rm{sh}
  - 101/00: ADD
  - 101/01: CMP
  - 101/10: AND
  - 101/11: MVN
  - All others are illegal.
- States: IDLE, DECODE, WR_IMM, LD_A, LD_B, EXEC, WR_REG, DONE.
- Reset (async): state=IDLE, IR=0, all strobes 0, readnum/writenum/vsel/shift/aluop=0, asel=bsel=0, done=err=0, w=1.
- Default in every state: strobes (write, loada, loadb, loadc, loads) are 0 and selects are 0, unless stated below. sximm8 follows IR continuously.
- IDLE: w=1. If s=1, capture IR=instr and go to DECODE next cycle. If s=0, stay.
- DECODE (no strobes):
  - MOV imm -> WR_IMM
  - MOV reg and MVN -> LD_B
  - ADD, CMP, AND -> LD_A
  - Illegal -> DONE with err flagged
- WR_IMM: writenum=Rn, vsel=10, write=1 -> DONE.
- LD_A: readnum=Rn, loada=1 -> LD_B.
- LD_B: readnum=Rm, loadb=1 -> EXEC.
- EXEC: shift=sh, bsel=0.
  - MOV reg: asel=1, aluop=00.
  - MVN: asel=1, aluop=11.
  - ADD/CMP/AND: asel=0, aluop=op.
  - CMP: loads=1, loadc=0 -> DONE.
  - All others: loadc=1, loads=0 -> WR_REG.
- WR_REG: writenum=Rd, vsel=00, write=1 -> DONE.
- DONE: done=1; err=1 iff illegal; -> IDLE.
- Latency, counted from the accept edge to the cycle done=1:
  - MOV imm: 3
  - MOV reg / MVN: 5
  - CMP: 5
  - ADD / AND: 6
  - Illegal: 2
- s outside IDLE is ignored; IR does not change while busy.
- s held high continuously: a new instruction is accepted on the first IDLE cycle, giving back-to-back execution with one IDLE cycle between instructions.
- Reset mid-operation: immediate return to IDLE; no write or loadc is issued afterward.
- At most one of write/loadc/loads is high in any cycle. write is never high in the same cycle as loada or loadb.
- Outputs are Moore, decoded from state and IR only; no combinational path from s or instr to any output.

Test Plan:
- Reset while in EXEC of ADD -> next cycle w=1, write=0, loadc=0; a subsequent MOV imm completes normally.
- MOV R3,#-5 (instr=16'hD3FB), s=1 for one cycle -> cycle 2: write=1, writenum=3, vsel=10, sximm8=16'hFFFB; cycle 3: done=1, err=0.
- ADD R2,R1,R0 LSL (instr=16'hA148) -> LD_A readnum=1; LD_B readnum=0; EXEC aluop=00, shift=01, loadc=1; WR_REG writenum=2, write=1; done at cycle 6.
- CMP R5,R6 (instr=16'hAD06) -> EXEC loads=1, loadc=0; no write in any cycle; done at cycle 5.
- Illegal instr=16'hE000 -> done=1 and err=1 at cycle 2; no strobe ever asserted.
- s toggled every cycle during a MVN -> only the first s is accepted, IR is unchanged, exactly one done pulse; s held high over two MOV imm instructions -> two done pulses 4 cycles apart.
